// File: rtl/bitwise_alu_pkg.sv
// Shared op codes and sizing helper for the registered bitwise logic unit.
package bitwise_alu_pkg;

    localparam logic [2:0] OP_AND     = 3'd0;
    localparam logic [2:0] OP_OR      = 3'd1;
    localparam logic [2:0] OP_XOR     = 3'd2;
    localparam logic [2:0] OP_NAND    = 3'd3;
    localparam logic [2:0] OP_ACC_XOR = 3'd4;
    localparam logic [2:0] OP_ACC_AND = 3'd5;
    localparam logic [2:0] OP_ACC_CLR = 3'd6;
    localparam logic [2:0] OP_POPCNT  = 3'd7;

    // Bits needed to hold a ones-count of 0..width.
    function automatic int popcount_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/bitwise_alu_pipe_popcount.sv
// Purely combinational ones-counter over a WIDTH-bit word.
module popcount
    import bitwise_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]                 data,
    output logic [popcount_width(WIDTH)-1:0] count
);

    localparam int CW = popcount_width(WIDTH);

    always_comb begin
        // NOTE: assigning a default before the loop keeps this purely combinational (no latch).
        count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count = count + CW'(data[i]);
        end
    end

endmodule

// File: rtl/bitwise_alu_pipe.sv
// Registered bitwise logic unit: op mux, accumulator, single output register
// with valid/ready backpressure, and a saturating accepted-beat counter.
module bitwise_alu_pipe
    import bitwise_alu_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [2:0]         in_op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_zero,
    output logic               out_parity,
    output logic [COUNT_W-1:0] txn_count
);

    localparam int CW = popcount_width(WIDTH);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] result;
    logic [CW-1:0]    pop_count;
    logic             accept;

    // A pop frees the single output slot in the same cycle.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    popcount #(.WIDTH(WIDTH)) u_popcount (
        .data  (in_a ^ in_b),
        .count (pop_count)
    );

    always_comb begin
        result   = '0;
        acc_next = acc;
        case (in_op)
            OP_AND:     result = in_a & in_b;
            OP_OR:      result = in_a | in_b;
            OP_XOR:     result = in_a ^ in_b;
            OP_NAND:    result = ~(in_a & in_b);
            OP_ACC_XOR: begin
                acc_next = acc ^ in_a ^ in_b;
                result   = acc_next;
            end
            OP_ACC_AND: begin
                acc_next = acc & (in_a | in_b);
                result   = acc_next;
            end
            OP_ACC_CLR: begin
                result   = acc;
                acc_next = '0;
            end
            OP_POPCNT:  result = WIDTH'(pop_count);
            default:    result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_zero   <= 1'b1;
            out_parity <= 1'b0;
            acc        <= '0;
            txn_count  <= '0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_data   <= result;
            out_zero   <= (result == '0);
            out_parity <= ^result;
            acc        <= acc_next;
            if (txn_count != '1) begin
                txn_count <= txn_count + COUNT_W'(1);
            end
        end else if (out_ready) begin
            // Pop without a new beat: data register keeps its last value.
            out_valid <= 1'b0;
        end
    end

endmodule
